// File: rtl/window3x3_gen.sv
// window3x3_gen: turns a raster pixel stream into 3x3 neighbourhoods for MIN9
// using two line buffers and a 3x3 shift window.
module window3x3_gen #(
   parameter int IMG_WIDTH = 640,
   parameter int DATA_W = 8,
   parameter int COL_W = 10
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              sof,
   input  logic              pixel_in_valid,
   input  logic [DATA_W-1:0] pixel_in,
   output logic              Enable,
   output logic [DATA_W-1:0] pixel_1,
   output logic [DATA_W-1:0] pixel_2,
   output logic [DATA_W-1:0] pixel_3,
   output logic [DATA_W-1:0] pixel_4,
   output logic [DATA_W-1:0] pixel_5,
   output logic [DATA_W-1:0] pixel_6,
   output logic [DATA_W-1:0] pixel_7,
   output logic [DATA_W-1:0] pixel_8,
   output logic [DATA_W-1:0] pixel_9,
   output logic [1:0]        row_cnt
);
   logic [DATA_W-1:0] lb1 [IMG_WIDTH];
   logic [DATA_W-1:0] lb2 [IMG_WIDTH];
   logic [DATA_W-1:0] win [9];
   logic [DATA_W-1:0] lb1_rd, lb2_rd;
   logic [COL_W-1:0]  col, cur_col, nxt_col;
   logic [1:0]        cur_row, nxt_row;
   logic              last;

   // sof restarts the frame on the pixel it qualifies
   always_comb begin
      cur_col = sof ? '0 : col;
      cur_row = sof ? 2'd0 : row_cnt;
      last    = cur_col == COL_W'(IMG_WIDTH - 1);
      nxt_col = last ? '0 : cur_col + COL_W'(1);
      nxt_row = (last && cur_row != 2'd2) ? cur_row + 2'd1 : cur_row;
      lb1_rd  = lb1[cur_col];
      lb2_rd  = lb2[cur_col];
   end

   always_ff @(posedge clock)
      if (pixel_in_valid) begin
         lb2[cur_col] <= lb1_rd;
         lb1[cur_col] <= pixel_in;
      end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         col     <= '0;
         row_cnt <= 2'd0;
         Enable  <= 1'b0;
         for (int i = 0; i < 9; i++) win[i] <= '0;
      end else begin
         Enable <= pixel_in_valid && cur_row == 2'd2 && cur_col >= COL_W'(2);
         if (pixel_in_valid) begin
            col     <= nxt_col;
            row_cnt <= nxt_row;
            for (int r = 0; r < 3; r++) begin
               win[3*r]   <= win[3*r+1];
               win[3*r+1] <= win[3*r+2];
            end
            win[2] <= lb2_rd;
            win[5] <= lb1_rd;
            win[8] <= pixel_in;
         end
      end

   assign pixel_1 = win[0];
   assign pixel_2 = win[1];
   assign pixel_3 = win[2];
   assign pixel_4 = win[3];
   assign pixel_5 = win[4];
   assign pixel_6 = win[5];
   assign pixel_7 = win[6];
   assign pixel_8 = win[7];
   assign pixel_9 = win[8];
endmodule

// File: tb/tb_window3x3_gen.sv
// tb_window3x3_gen: scoreboard bench; the model indexes the pixel history of the
// current frame directly to form each expected 3x3 window.
module tb_window3x3_gen;
   localparam int W = 4;
   logic       clock = 1'b0, reset_n = 1'b0, sof = 1'b0, pixel_in_valid = 1'b0;
   logic [7:0] pixel_in = 8'd0;
   logic       Enable;
   logic [7:0] pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8, pixel_9;
   logic [1:0] row_cnt;
   int         checks = 0, errors = 0, windows = 0;
   logic [71:0] exp_q[$];
   logic [7:0]  hist[$];
   logic [71:0] act;

   always #5 clock = ~clock;

   window3x3_gen #(.IMG_WIDTH(W), .DATA_W(8), .COL_W(2)) dut (
      .clock(clock), .reset_n(reset_n), .sof(sof), .pixel_in_valid(pixel_in_valid),
      .pixel_in(pixel_in), .Enable(Enable),
      .pixel_1(pixel_1), .pixel_2(pixel_2), .pixel_3(pixel_3),
      .pixel_4(pixel_4), .pixel_5(pixel_5), .pixel_6(pixel_6),
      .pixel_7(pixel_7), .pixel_8(pixel_8), .pixel_9(pixel_9),
      .row_cnt(row_cnt)
   );

   assign act = {pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8, pixel_9};

   task automatic check(input string name, input logic [71:0] got, input logic [71:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   function automatic logic [1:0] model_row();
      int r = hist.size() / W;
      return r > 2 ? 2'd2 : 2'(r);
   endfunction

   task automatic send(input logic s, input logic v, input logic [7:0] p);
      int n;
      logic [71:0] e;
      @(negedge clock);
      check("row_cnt", 72'(row_cnt), 72'(model_row()));
      sof = s;
      pixel_in_valid = v;
      pixel_in = p;
      if (v) begin
         if (s) hist.delete();
         hist.push_back(p);
         n = hist.size() - 1;
         if (n / W >= 2 && n % W >= 2) begin
            e = '0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  e = {e[63:0], hist[n - (2 - i) * W - (2 - j)]};
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic drain(input string name, input int start, input int want);
      repeat (3) send(1'b0, 1'b0, 8'd0);
      check({name, "_queue_empty"}, 72'(exp_q.size()), 72'(0));
      check({name, "_window_count"}, 72'(windows - start), 72'(want));
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1;
      reset_n = 1'b0;
      sof = 1'b0;
      pixel_in_valid = 1'b0;
      hist.delete();
      #1;
      check("async_reset_enable", 72'(Enable), 72'(1'b0));
      check("async_reset_window", act, 72'(0));
      check("async_reset_row_cnt", 72'(row_cnt), 72'(0));
      check("async_reset_queue", 72'(exp_q.size()), 72'(0));
      @(negedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic pv;
      forever begin
         @(posedge clock);
         pv = pixel_in_valid;
         @(negedge clock);
         if (reset_n) begin
            if (Enable) begin
               windows++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_enable: got window %h expected no window", act);
               end else check("window", act, exp_q.pop_front());
            end
            if (!pv) check("stall_enable", 72'(Enable), 72'(1'b0));
         end
      end
   end

   initial begin
      int start, h;
      #1;
      check("time0_enable", 72'(Enable), 72'(1'b0));
      check("time0_window", act, 72'(0));
      check("time0_row_cnt", 72'(row_cnt), 72'(0));
      @(negedge clock);
      #1;
      reset_n = 1'b1;
      start = windows;
      for (int i = 0; i < 16; i++) send(i == 0, 1'b1, 8'(i));
      drain("full_rate", start, 4);
      start = windows;
      for (int i = 0; i < 16; i++) begin
         send(i == 0, 1'b1, 8'(i));
         send(1'b0, 1'b0, 8'hff);
      end
      drain("toggle_valid", start, 4);
      start = windows;
      for (int i = 0; i < 10; i++) send(i == 0, 1'b1, 8'(i));
      for (int i = 0; i < 16; i++) send(i == 0, 1'b1, 8'(100 + i));
      drain("sof_restart", start, 4);
      start = windows;
      for (int i = 0; i < 10; i++) send(i == 0, 1'b1, 8'(i));
      do_reset();
      for (int i = 0; i < 16; i++) send(1'b0, 1'b1, 8'(i));
      drain("after_reset", start, 4);
      for (int f = 0; f < 6; f++) begin
         h = 3 + int'($urandom_range(0, 6));
         start = windows;
         for (int n = 0; n < W * h; n++) begin
            while ($urandom_range(0, 3) == 0) send(1'b0, 1'b0, 8'($urandom));
            send(n == 0, 1'b1, 8'($urandom));
         end
         drain("random_frame", start, (W - 2) * (h - 2));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
